// File: rtl/ps2_clk_edge_filter.sv
// PS/2 clock conditioner: synchroniser, divided sampling, run-length glitch filter, edge strobes, idle flag.
// Define PS2_GLITCH_CNT_EN to add the saturating o_glitch_cnt output.
module ps2_clk_edge_filter #(
  parameter int SAMPLING_BIT_SIZE = 5,
  parameter int SYNC_STAGES       = 2,
  parameter int FILTER_LEN        = 4,
  parameter int IDLE_SAMPLES      = 64
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_sclr,
  input  logic       i_ps2_clk,
  output logic       o_clk_filt,
  output logic       o_negedge_en,
  output logic       o_posedge_en,
  output logic       o_idle
`ifdef PS2_GLITCH_CNT_EN
  ,
  output logic [7:0] o_glitch_cnt
`endif
);

  localparam int STAB_W = $clog2(FILTER_LEN + 1);
  localparam int IDLE_W = $clog2(IDLE_SAMPLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_SAMPLES);

  typedef enum logic {ST_STABLE, ST_QUAL} state_t;

  logic [SYNC_STAGES-1:0]       sync_reg;
  logic [SAMPLING_BIT_SIZE-1:0] samp_cnt_reg;
  state_t                       state_reg, state_next;
  logic [STAB_W-1:0]            stab_cnt_reg, stab_cnt_next;
  logic                         clk_filt_reg, clk_filt_next;
  logic                         clk_filt_dly_reg;
  logic [IDLE_W-1:0]            idle_cnt_reg, idle_cnt_next;
  logic                         negedge_reg, posedge_reg;
  logic                         s_ps2_sync;
  logic                         s_sample_en;
  logic                         differs;
`ifdef PS2_GLITCH_CNT_EN
  logic                         glitch_evt;
  logic [7:0]                   glitch_cnt_reg;
`endif

  assign s_ps2_sync  = sync_reg[SYNC_STAGES-1];
  assign s_sample_en = &samp_cnt_reg;
  assign differs     = (s_ps2_sync != clk_filt_reg);

  // Filter decisions and the idle count only move on sample enables.
  always_comb begin
    state_next    = state_reg;
    stab_cnt_next = stab_cnt_reg;
    clk_filt_next = clk_filt_reg;
    idle_cnt_next = idle_cnt_reg;
`ifdef PS2_GLITCH_CNT_EN
    glitch_evt    = 1'b0;
`endif
    if (s_sample_en) begin
      case (state_reg)
        ST_STABLE: begin
          if (differs) begin
            if (FILTER_LEN == 1) begin
              clk_filt_next = ~clk_filt_reg;
            end else begin
              stab_cnt_next = STAB_W'(1);
              state_next    = ST_QUAL;
            end
          end
        end
        ST_QUAL: begin
          if (differs) begin
            if (int'(stab_cnt_reg) + 1 == FILTER_LEN) begin
              clk_filt_next = ~clk_filt_reg;
              stab_cnt_next = '0;
              state_next    = ST_STABLE;
            end else begin
              stab_cnt_next = stab_cnt_reg + 1'b1;
            end
          end else begin
            stab_cnt_next = '0;
            state_next    = ST_STABLE;
`ifdef PS2_GLITCH_CNT_EN
            glitch_evt    = 1'b1;
`endif
          end
        end
        default: begin
          stab_cnt_next = '0;
          state_next    = ST_STABLE;
        end
      endcase
      // Using the next level lets o_idle drop in the same clk the filtered level falls.
      if (!clk_filt_next) begin
        idle_cnt_next = '0;
      end else if (idle_cnt_reg != IDLE_MAX) begin
        idle_cnt_next = idle_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_reg         <= '1;
      samp_cnt_reg     <= '0;
      state_reg        <= ST_STABLE;
      stab_cnt_reg     <= '0;
      clk_filt_reg     <= 1'b1;
      clk_filt_dly_reg <= 1'b1;
      idle_cnt_reg     <= '0;
      negedge_reg      <= 1'b0;
      posedge_reg      <= 1'b0;
    end else if (i_sclr) begin
      sync_reg         <= '1;
      samp_cnt_reg     <= '0;
      state_reg        <= ST_STABLE;
      stab_cnt_reg     <= '0;
      clk_filt_reg     <= 1'b1;
      clk_filt_dly_reg <= 1'b1;
      idle_cnt_reg     <= '0;
      negedge_reg      <= 1'b0;
      posedge_reg      <= 1'b0;
    end else begin
      sync_reg         <= {sync_reg[SYNC_STAGES-2:0], i_ps2_clk};
      samp_cnt_reg     <= samp_cnt_reg + 1'b1;
      state_reg        <= state_next;
      stab_cnt_reg     <= stab_cnt_next;
      clk_filt_reg     <= clk_filt_next;
      clk_filt_dly_reg <= clk_filt_reg;
      idle_cnt_reg     <= idle_cnt_next;
      // Strobe fires the clk after the filtered level has changed.
      negedge_reg      <= clk_filt_dly_reg & ~clk_filt_reg;
      posedge_reg      <= ~clk_filt_dly_reg & clk_filt_reg;
    end
  end

`ifdef PS2_GLITCH_CNT_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      glitch_cnt_reg <= '0;
    end else if (i_sclr) begin
      glitch_cnt_reg <= '0;
    end else if (glitch_evt && (glitch_cnt_reg != 8'hFF)) begin
      glitch_cnt_reg <= glitch_cnt_reg + 8'd1;
    end
  end

  assign o_glitch_cnt = glitch_cnt_reg;
`endif

  assign o_clk_filt   = clk_filt_reg;
  assign o_negedge_en = negedge_reg;
  assign o_posedge_en = posedge_reg;
  assign o_idle       = (idle_cnt_reg == IDLE_MAX);

endmodule
